// File: rtl/interpo_pkg.sv
// Shared defaults and FSM state encoding for the interpolator coefficient reader.
package interpo_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/interpo_coef_fifo.sv
// Output buffer: registered head word in front of a small ring buffer; count covers both.
module interpo_coef_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  mem_cnt_q, mem_cnt_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              head_vld_q, head_vld_d;
    logic              pop, mem_empty, bypass, mem_we, mem_rd;

    always_comb begin
        pop        = head_vld_q & out_ready;
        mem_empty  = (mem_cnt_q == '0);
        // An empty ring lets an incoming word go straight to the head register.
        bypass     = push & mem_empty & (~head_vld_q | pop);
        mem_we     = push & ~bypass;
        mem_rd     = pop & ~mem_empty;
        head_d     = head_q;
        head_vld_d = head_vld_q;
        if (bypass) begin
            head_d     = push_data;
            head_vld_d = 1'b1;
        end else if (mem_rd) begin
            head_d = mem_q[rd_ptr_q];
        end else if (pop) begin
            head_vld_d = 1'b0;
        end
        wr_ptr_d  = wr_ptr_q + PTR_W'(mem_we);
        rd_ptr_d  = rd_ptr_q + PTR_W'(mem_rd);
        mem_cnt_d = mem_cnt_q + CNT_W'(mem_we) - CNT_W'(mem_rd);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign out_data  = head_q;
    assign out_valid = head_vld_q;
    assign count     = mem_cnt_q + CNT_W'(head_vld_q);

endmodule

// File: rtl/interpo_coef_reader.sv
// Burst reader: fetches count coefficient words from an Avalon-MM table (read latency 1)
// starting at base, wrapping the address, and streams them out over Avalon-ST.
module interpo_coef_reader
    import interpo_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base,
    input  logic [ADDR_W:0]     count,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_read,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic [DATA_W-1:0]   avm_readdata,
    output logic [DATA_W-1:0]   src_data,
    output logic                src_valid,
    input  logic                src_ready
);

    localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]  ONE_C   = (ADDR_W + 1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic              inflight_q, inflight_d;
    logic              done_q, done_d;
    logic              rd_en;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [CNT_W-1:0]  occ;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        rd_en    = 1'b0;
        // Words already buffered plus the one on the bus must leave room for another.
        occ      = fifo_cnt + CNT_W'(inflight_q);
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        addr_d   = base;
                        remain_d = count;
                        state_d  = ST_READ;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_READ: begin
                if (occ < DEPTH_C) begin
                    rd_en    = 1'b1;
                    addr_d   = addr_q + 1'b1;
                    remain_d = remain_q - ONE_C;
                    if (remain_q == ONE_C) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!inflight_q && fifo_cnt == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        inflight_d = rd_en;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    // Return data is only accepted when a read was issued in the previous cycle.
    interpo_coef_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (avm_readdata),
        .out_data  (src_data),
        .out_valid (src_valid),
        .out_ready (src_ready),
        .count     (fifo_cnt)
    );

    assign avm_address    = addr_q;
    assign avm_read       = rd_en;
    assign avm_chipselect = rd_en;
    assign avm_byteenable = '1;
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;

endmodule

// File: tb/tb_interpo_coef_reader.sv
// Directed bench for interpo_coef_reader against a latency-1 table holding word i = 0x1000+i.
module tb_interpo_coef_reader;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [4:0]  base;
    logic [5:0]  count;
    logic        busy, done;
    logic [4:0]  avm_address;
    logic        avm_chipselect, avm_read;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic [31:0] src_data;
    logic        src_valid, src_ready;
    logic        fixed_ready, rnd_mode, rnd_bit;

    int n_chk = 0, n_pass = 0, cyc = 0, st_cyc = 0;
    logic [31:0] rx_q[$];
    logic [4:0]  ad_q[$];
    int first_vld, first_rd, first_rx, last_rx, done_cnt, done_cyc;
    int viol, max_fifo, hold_viol, vld_seen;
    logic        hold_pend;
    logic [31:0] hold_data;

    interpo_coef_reader dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .count(count),
        .busy(busy), .done(done), .avm_address(avm_address),
        .avm_chipselect(avm_chipselect), .avm_read(avm_read),
        .avm_byteenable(avm_byteenable), .avm_readdata(avm_readdata),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end
    assign src_ready = rnd_mode ? rnd_bit : fixed_ready;

    // Table slave, fixed read latency of one cycle.
    always @(posedge clk)
        avm_readdata <= avm_read ? (32'h1000 + 32'(avm_address)) : 32'hDEAD_BEEF;

    always @(negedge clk) begin
        if (src_valid && src_ready) begin
            rx_q.push_back(src_data);
            if (first_rx < 0) first_rx = cyc;
            last_rx = cyc;
        end
        if (src_valid) begin
            vld_seen++;
            if (first_vld < 0) first_vld = cyc;
        end
        if (avm_read) begin
            ad_q.push_back(avm_address);
            if (first_rd < 0) first_rd = cyc;
            if (int'(dut.fifo_cnt) + int'(dut.inflight_q) >= DEPTH) viol++;
        end
        if (int'(dut.fifo_cnt) > max_fifo) max_fifo = int'(dut.fifo_cnt);
        if (hold_pend && (!src_valid || src_data !== hold_data)) hold_viol++;
        hold_pend = src_valid && !src_ready;
        hold_data = src_data;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_logs();
        rx_q.delete();
        ad_q.delete();
        first_vld = -1; first_rd = -1; first_rx = -1; last_rx = -1;
        done_cnt = 0; done_cyc = -1; viol = 0; max_fifo = 0;
        hold_viol = 0; vld_seen = 0; hold_pend = 1'b0;
    endtask

    task automatic pulse_start(input logic [4:0] b, input logic [5:0] c);
        @(posedge clk); #1;
        start = 1'b1; base = b; count = c; st_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 600 && done_cnt == 0; i++) begin
            @(posedge clk); #1;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    endtask

    task automatic chk_words(input string tag, input int b, input int n);
        int bad;
        bad = 0;
        chk({tag, "_nwords"}, 64'(rx_q.size()), 64'(n));
        for (int i = 0; i < n && i < rx_q.size(); i++)
            if (rx_q[i] !== 32'h1000 + 32'((b + i) % 32)) bad++;
        chk({tag, "_order_errs"}, 64'(bad), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base = '0; count = '0;
        fixed_ready = 1'b1; rnd_mode = 1'b0;
        clear_logs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_read", 64'(avm_read), 64'd0);
        chk("rst_cs", 64'(avm_chipselect), 64'd0);
        chk("rst_addr", 64'(avm_address), 64'd0);
        chk("rst_valid", 64'(src_valid), 64'd0);
        chk("rst_data", 64'(src_data), 64'd0);
        chk("byteenable", 64'(avm_byteenable), 64'hF);
        @(posedge clk); #1;
        reset = 1'b0;

        // Full table, ready held high.
        clear_logs();
        pulse_start(5'd0, 6'd32);
        chk("t1_busy_c1", 64'(busy), 64'd1);
        chk("t1_read_c1", 64'(avm_read), 64'd1);
        wait_done("t1");
        chk_words("t1", 0, 32);
        chk("t1_rd_lat", 64'(first_rd - st_cyc), 64'd1);
        chk("t1_vld_lat", 64'(first_vld - st_cyc), 64'd3);
        chk("t1_consec", 64'(last_rx - first_rx), 64'd31);
        chk("t1_busy_end", 64'(busy), 64'd0);

        // Address wrap.
        clear_logs();
        pulse_start(5'd30, 6'd4);
        wait_done("t2");
        chk("t2_nreads", 64'(ad_q.size()), 64'd4);
        if (ad_q.size() == 4) begin
            chk("t2_a0", 64'(ad_q[0]), 64'd30);
            chk("t2_a1", 64'(ad_q[1]), 64'd31);
            chk("t2_a2", 64'(ad_q[2]), 64'd0);
            chk("t2_a3", 64'(ad_q[3]), 64'd1);
        end
        chk_words("t2", 30, 4);

        // Random backpressure.
        clear_logs();
        rnd_mode = 1'b1;
        pulse_start(5'd0, 6'd32);
        wait_done("t3");
        rnd_mode = 1'b0;
        chk_words("t3", 0, 32);
        chk("t3_max_fifo_le4", 64'(max_fifo <= DEPTH), 64'd1);
        chk("t3_read_at_full", 64'(viol), 64'd0);
        chk("t3_hold_errs", 64'(hold_viol), 64'd0);

        // Zero-length request.
        clear_logs();
        pulse_start(5'd9, 6'd0);
        chk("t4_busy_c1", 64'(busy), 64'd1);
        wait_done("t4");
        chk("t4_done_lat", 64'(done_cyc - st_cyc), 64'd2);
        chk("t4_nreads", 64'(ad_q.size()), 64'd0);
        chk("t4_valid", 64'(vld_seen), 64'd0);

        // Start re-pulsed while busy must be ignored.
        clear_logs();
        pulse_start(5'd3, 6'd8);
        @(posedge clk); #1;
        start = 1'b1; base = 5'd7; count = 6'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t5");
        chk("t5_nreads", 64'(ad_q.size()), 64'd8);
        chk("t5_last_addr", 64'(ad_q.size() == 8 ? ad_q[7] : 5'd31), 64'd10);
        chk_words("t5", 3, 8);

        // Reset mid-burst with the output stalled.
        clear_logs();
        pulse_start(5'd0, 6'd32);
        for (int i = 0; i < 200 && rx_q.size() < 10; i++) begin
            @(posedge clk); #1;
        end
        fixed_ready = 1'b0;
        chk("t6_ten_words", 64'(rx_q.size()), 64'd10);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        chk("t6_read", 64'(avm_read), 64'd0);
        chk("t6_cs", 64'(avm_chipselect), 64'd0);
        chk("t6_addr", 64'(avm_address), 64'd0);
        chk("t6_valid", 64'(src_valid), 64'd0);
        chk("t6_data", 64'(src_data), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        fixed_ready = 1'b1;
        clear_logs();
        pulse_start(5'd0, 6'd2);
        wait_done("t6b");
        chk_words("t6b", 0, 2);
        if (rx_q.size() == 2) begin
            chk("t6b_w0", 64'(rx_q[0]), 64'h1000);
            chk("t6b_w1", 64'(rx_q[1]), 64'h1001);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/interpo_coef_reader.md
INTERPO_COEF_READER -- requirements
Module: interpo_coef_reader

Interface
REQ-001 Parameter ADDR_W, default 5, word-address width of the coefficient table.
REQ-002 Parameter DATA_W, default 32, coefficient word width.
REQ-003 Parameter FIFO_DEPTH, default 4, output buffer depth in words (power of two, >=2).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-007 base  in  ADDR_W  first word address, sampled with start.
REQ-008 count  in  ADDR_W+1  words to read (0..2^ADDR_W), sampled with start.
REQ-009 busy  out  1  high from the cycle after an accepted start until done.
REQ-010 done  out  1  one-cycle pulse at burst completion.
REQ-011 avm_address  out  ADDR_W  Avalon-MM master word address.
REQ-012 avm_chipselect  out  1  equals avm_read.
REQ-013 avm_read  out  1  read strobe; the slave has fixed read latency 1 and no waitrequest.
REQ-014 avm_byteenable  out  DATA_W/8  constant all-ones.
REQ-015 avm_readdata  in  DATA_W  read data, valid exactly one cycle after avm_read.
REQ-016 src_data  out  DATA_W  Avalon-ST coefficient word.
REQ-017 src_valid  out  1  src_data valid.
REQ-018 src_ready  in  1  downstream accepts when src_valid & src_ready.

Function
REQ-019 FSM states IDLE, READ, DRAIN; reset state IDLE.
REQ-020 IDLE: start=1 with count>0 latches base/count and enters READ; start=1 with count=0 enters DRAIN with no bus reads.
REQ-021 READ: avm_read=1 in a cycle only when fifo_count + inflight < FIFO_DEPTH; inflight is 1 if avm_read was high in the previous cycle, else 0.
REQ-022 Each issued read increments the address modulo 2^ADDR_W (base=31, count=3 reads 31,0,1) and decrements the remaining counter; remaining reaching 0 moves READ to DRAIN.
REQ-023 Read data is written into the FIFO in the cycle it arrives (one cycle after avm_read); src_valid rises the following cycle.
REQ-024 Latency: start in cycle 0 -> avm_read in cycle 1 -> src_valid in cycle 3.
REQ-025 With src_ready held high, sustained throughput is one word per cycle.
REQ-026 src_data/src_valid hold stable while src_valid=1 and src_ready=0; no word is dropped or duplicated.
REQ-027 DRAIN: once inflight=0 and the FIFO is empty, assert done for one cycle and return to IDLE; busy deasserts in that same cycle.
REQ-028 start while busy=1 is ignored; base/count changes while busy have no effect.
REQ-029 FIFO simultaneous push and pop at full or empty is legal; occupancy is unchanged.
REQ-030 Words are emitted strictly in address order.

Reset
REQ-031 Asserting reset at any time, including mid-burst, forces IDLE, flushes the FIFO, clears inflight, and drives busy=0, done=0, avm_read=0, avm_chipselect=0, avm_address=0, src_valid=0, and src_data=0.
REQ-032 A read data word returning in the first cycle after reset release is discarded.

Structure
REQ-033 Shared package interpo_pkg holds ADDR_W/DATA_W defaults and the FSM state typedef.
REQ-034 The output buffer is the sub-module interpo_coef_fifo (synchronous, FIFO_DEPTH x DATA_W, first-word registered output, count output).

Verification
REQ-035 base=0, count=32, src_ready=1 on a 32-word model holding word i = 0x1000+i -> 32 words 0x1000..0x101F on consecutive cycles, first src_valid 3 cycles after start, one done pulse.
REQ-036 base=30, count=4 -> addresses 30,31,0,1 and data 0x101E,0x101F,0x1000,0x1001.
REQ-037 count=32 with src_ready toggled pseudo-randomly (50%) -> all 32 words in order, fifo_count never exceeds 4, avm_read never issued while count+inflight=4.
REQ-038 start with count=0 -> no avm_read, done pulse 2 cycles after start, src_valid stays 0.
REQ-039 start re-pulsed mid-burst with base=7 -> ignored; original sequence completes unchanged.
REQ-040 reset asserted after 10 words of a 32-word burst with src_ready=0 -> all outputs zero immediately; a new burst with base=0, count=2 then returns exactly 0x1000, 0x1001.
